// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: host-side byte/baud inputs and serial/status outputs of uart_transmitter.
// The master modport is the host side; the slave modport is the transmitter.
interface uart_transmitter_if;
    logic [7:0] din;
    logic       wr_en;
    logic       clken;
    logic       tx;
    logic       tx_busy;
    logic       full;
    logic       empty;
    logic       overflow;

    modport master (
        output din, wr_en, clken,
        input  tx, tx_busy, full, empty, overflow
    );

    modport slave (
        input  din, wr_en, clken,
        output tx, tx_busy, full, empty, overflow
    );
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter: FIFO-buffered 8N1 UART serialiser stepped by a 1x baud enable (clken).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit(s).
module uart_transmitter #(
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    uart_transmitter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STOP_N = (STOP_BITS == 2) ? 2 : 1;
    localparam logic STOP_LAST = 1'(STOP_N - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd3} state_t;
`endif

    state_t             r_state;
    logic               r_tx;
    logic [2:0]         r_idx;
    logic               r_stop_cnt;
    logic [7:0]         r_sh;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_full;
    logic               r_empty;
    logic               r_overflow;
    logic [7:0]         r_mem [FIFO_DEPTH];

    state_t             w_state_next;
    logic               w_tx_next;
    logic [2:0]         w_idx_next;
    logic               w_stop_cnt_next;
    logic [7:0]         w_sh_next;
    logic               w_pop;
    logic               w_push;
    logic [CNT_W-1:0]   w_count_next;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write then.
    assign w_push = bus.wr_en && (!r_full || w_pop);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_tx_next       = r_tx;
        w_idx_next      = r_idx;
        w_stop_cnt_next = r_stop_cnt;
        w_sh_next       = r_sh;
        w_pop           = 1'b0;
        if (bus.clken) begin
            case (r_state)
                IDLE: begin
                    // The IDLE period doubles as the last stop period, so frames run back to back.
                    if (!r_empty) begin
                        w_pop        = 1'b1;
                        w_sh_next    = r_mem[r_rd_ptr];
                        w_tx_next    = 1'b0;
                        w_idx_next   = 3'd0;
                        w_state_next = DATA;
                    end else begin
                        w_tx_next = 1'b1;
                    end
                end
                DATA: begin
                    w_tx_next       = r_sh[r_idx];
                    w_idx_next      = r_idx + 3'd1;
                    w_stop_cnt_next = 1'b0;
                    if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    w_tx_next    = ^r_sh;
                    w_state_next = STOP;
                end
`endif
                STOP: begin
                    w_tx_next = 1'b1;
                    if (r_stop_cnt == STOP_LAST) begin
                        w_stop_cnt_next = 1'b0;
                        w_state_next    = IDLE;
                    end else begin
                        w_stop_cnt_next = r_stop_cnt + 1'b1;
                    end
                end
                default: begin
                    w_tx_next    = 1'b1;
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tx       <= 1'b1;
            r_idx      <= 3'd0;
            r_stop_cnt <= 1'b0;
            r_sh       <= 8'd0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tx       <= w_tx_next;
            r_idx      <= w_idx_next;
            r_stop_cnt <= w_stop_cnt_next;
            r_sh       <= w_sh_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count    <= w_count_next;
            r_full     <= (w_count_next == CNT_W'(FIFO_DEPTH));
            r_empty    <= (w_count_next == '0);
            r_overflow <= bus.wr_en && r_full && !w_pop;
        end
    end

    // Storage needs no reset: the cleared pointers and count make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.din;
        end
    end

    assign bus.tx       = r_tx;
    assign bus.tx_busy  = (r_state != IDLE);
    assign bus.full     = r_full;
    assign bus.empty    = r_empty;
    assign bus.overflow = r_overflow;
endmodule
